uart_tx_fifo: RTL



---
 rtl/uart_tx_fifo.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small byte FIFO.
// Frames are LSB first, with optional parity and one or two stop bits.
module uart_tx_fifo #(
    parameter logic [13:0] KBAUD     = 14'd10416,
    parameter int          DEPTH     = 4,
    parameter int          PARITY    = 0,
    parameter int          STOP_BITS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               data_IN,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic                     tx_out,
    output logic                     busy,
    output logic                     Tx_done,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(KBAUD) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(KBAUD - 14'd1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t         state_reg, state_next;
    logic [BW-1:0]  baud_reg, baud_next;
    logic [2:0]     bit_reg, bit_next;
    logic           stop_reg, stop_next;
    logic [7:0]     shift_reg, shift_next;
    logic           par_reg, par_next;
    logic           tx_reg, tx_next;
    logic           busy_reg, busy_next;
    logic           done_reg, done_next;
    logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           wr_ready_reg, wr_ready_next;

    logic [7:0]     mem [DEPTH];
    logic [7:0]     head;
    logic           push, load, baud_end, fifo_not_empty;

    assign push           = wr_valid & wr_ready_reg;
    assign head           = mem[rd_ptr_reg];
    assign baud_end       = (baud_reg == BAUD_LAST);
    assign fifo_not_empty = (cnt_reg != '0);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= data_IN;
    end

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg + 1'b1;
        bit_next   = bit_reg;
        stop_next  = stop_reg;
        shift_next = shift_reg;
        par_next   = par_reg;
        tx_next    = tx_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        load       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                baud_next = '0;
                if (fifo_not_empty)
                    load = 1'b1;
            end
            S_START: begin
                if (baud_end) begin
                    baud_next  = '0;
                    tx_next    = shift_reg[0];
                    bit_next   = '0;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (bit_reg == 3'd7) begin
                        stop_next = 1'b0;
                        if (PARITY != 0) begin
                            tx_next    = par_reg;
                            state_next = S_PARITY;
                        end else begin
                            tx_next    = 1'b1;
                            state_next = S_STOP;
                        end
                    end else begin
                        bit_next   = bit_reg + 1'b1;
                        shift_next = {1'b0, shift_reg[7:1]};
                        tx_next    = shift_reg[1];
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    baud_next  = '0;
                    tx_next    = 1'b1;
                    stop_next  = 1'b0;
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (STOP_BITS == 2 && !stop_reg) begin
                        stop_next = 1'b1;
                    end else begin
                        done_next = 1'b1;
                        // Chain straight into the next start bit when more data waits.
                        if (fifo_not_empty) begin
                            load = 1'b1;
                        end else begin
                            state_next = S_IDLE;
                            busy_next  = 1'b0;
                        end
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (load) begin
            shift_next = head;
            par_next   = (PARITY == 1) ? ~^head : ^head;
            baud_next  = '0;
            tx_next    = 1'b0;
            busy_next  = 1'b1;
            state_next = S_START;
        end

        cnt_next = cnt_reg;
        if (push && !load)
            cnt_next = cnt_reg + 1'b1;
        else if (!push && load)
            cnt_next = cnt_reg - 1'b1;
        wr_ready_next = (cnt_next != CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            baud_reg     <= '0;
            bit_reg      <= '0;
            stop_reg     <= 1'b0;
            shift_reg    <= '0;
            par_reg      <= 1'b0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            cnt_reg      <= '0;
            wr_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_reg      <= bit_next;
            stop_reg     <= stop_next;
            shift_reg    <= shift_next;
            par_reg      <= par_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            cnt_reg      <= cnt_next;
            wr_ready_reg <= wr_ready_next;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (load)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    assign wr_ready = wr_ready_reg;
    assign tx_out   = tx_reg;
    assign busy     = busy_reg;
    assign Tx_done  = done_reg;
    assign fifo_cnt = cnt_reg;

endmodule
